byte_word_loader: RTL and testbench
===================================

# byte_word_loader

Byte-stream-to-word loader for the program RAM: accepts 8-bit bytes over a valid/ready handshake, packs each group of four little-endian into a 32-bit word and issues one single-cycle write per word at auto-incrementing word addresses. It is the write-side counterpart of the top-level byte serializer that streams RAM words out 8 bits per cycle on `uo_out`, letting data RAM be preloaded from the 8-bit pins before the CPU runs.

## Interface
- `ADDR_W`, 5, word address width; `DEPTH` = 2**ADDR_W words (32)
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse; begins a load session (ignored unless IDLE)
- `num_words`  in  ADDR_W+1  words in session, sampled on accepted `start`
- `byte_valid`  in  1  `byte_data` is valid
- `byte_data`  in  8  incoming byte
- `byte_ready`  out  1  loader accepts a byte this cycle
- `mem_we`  out  1  RAM write strobe, one cycle per word
- `mem_addr`  out  ADDR_W  RAM word address
- `mem_wdata`  out  32  assembled word
- `busy`  out  1  session in progress (any state but IDLE)
- `done`  out  1  one-cycle pulse at session end
- `words_written`  out  ADDR_W+1  words written in current/last session
- `chk_err`  out  1  checksum mismatch flag (see Configuration)

## Operation
- States: IDLE, LOAD, WRITE, CHECK (macro only), DONE.
- IDLE: `byte_ready`=0. `start`=1 → latch count = min(`num_words`, DEPTH); clear `mem_addr`, `words_written`, byte index, `chk_err`, checksum. Count 0 → DONE; else → LOAD.
- LOAD: `byte_ready`=1. Byte accepted when `byte_valid`&`byte_ready` at rising edge; placed into lane `idx` (first byte → `[7:0]`, fourth → `[31:24]`); `idx` increments mod 4. Fourth byte accepted → WRITE.
- WRITE: one cycle; `mem_we`=1, `mem_wdata` = assembled word, `mem_addr` = current address; `byte_ready`=0. On exit: `mem_addr`++, `words_written`++. If `words_written` (after increment) = count → CHECK (macro) or DONE; else → LOAD.
- DONE: `done`=1 for exactly one cycle → IDLE. `mem_addr` and `words_written` hold until next `start`.
- `start` while busy: ignored, no effect on state or counters.
- `byte_valid` while not ready: byte not consumed; source holds it.
- Address never wraps: count clamped to DEPTH, so last write is at DEPTH-1.
- Reset mid-session: all state and outputs to reset values immediately; partial word discarded; no write issued.
- `mem_wdata` holds its last value outside WRITE; only `mem_we` qualifies it.

## Timing
- Reset values: `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `words_written`=0, `chk_err`=0; state IDLE.
- All outputs registered; `byte_ready` a pure function of state.
- `start` sampled at edge T → `busy`=1 and `byte_ready`=1 from cycle T+1.
- Fourth byte accepted at edge N → `mem_we`=1 during cycle N+1 → `byte_ready`=1 again from N+2.
- Peak throughput: 5 cycles per word (4 accept + 1 write).
- Last write at cycle W → `done` pulse at cycle W+1 (no macro); `busy` drops the cycle after `done`.
- `num_words`=0: `done` pulses the cycle after `start`, no writes.

## Configuration
- `LOADER_CHECKSUM_EN` defined: running XOR of every accepted data byte. After final WRITE → CHECK: `byte_ready`=1, accept one byte; `chk_err` <= (byte != running XOR), held until next accepted `start`; then DONE. Count 0: CHECK still taken, expected value 0x00.
- Not defined: no CHECK state, no checksum logic, `chk_err` tied 0.

## Test plan
- Reset: hold `rst_n`=0 → all outputs 0; release, no `start` → `byte_ready`=0, `mem_we` never asserts.
- `start`, `num_words`=2, bytes 0x11,0x22,0x33,0x44,0xAA,0xBB,0xCC,0xDD back-to-back → writes 0x44332211 @0, 0xDDCCBBAA @1, one `mem_we` cycle each, `done` one cycle, `words_written`=2.
- Same stream with `byte_valid` toggled 1/0 every cycle and a `start` pulse mid-session → identical writes, second `start` ignored.
- `num_words`=40 → exactly 32 writes, addresses 0..31, no wrap, `words_written`=32.
- `rst_n` pulsed low after 2 bytes of word 1 → no write, all outputs 0; new session writes from address 0.
- `LOADER_CHECKSUM_EN`, `num_words`=1, bytes 0x01,0x02,0x04,0x08 then 0x0F → `chk_err`=0; rerun with 0x0E → `chk_err`=1, held until next `start`.

Source files
------------

// File: rtl/byte_word_loader.sv
// byte_word_loader: packs a valid/ready byte stream little-endian into 32-bit
// words and writes them to program RAM at auto-incrementing word addresses.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          one-cycle session start, honoured only when idle
//   num_words      words in the session, clamped to DEPTH, sampled on start
//   byte_valid     byte_data holds a byte
//   byte_data      incoming byte
//   byte_ready     loader takes a byte this cycle (LOAD or CHECK state)
//   mem_we         single-cycle RAM write strobe per word
//   mem_addr       RAM word address
//   mem_wdata      assembled word, qualified by mem_we
//   busy           session in progress
//   done           one-cycle pulse at session end
//   words_written  words written in the current/last session
//   chk_err        checksum mismatch flag
//
// Optional feature: define LOADER_CHECKSUM_EN to require one trailing byte
// equal to the XOR of all data bytes; a mismatch sets chk_err until the next
// accepted start. Without it chk_err is tied low.
module byte_word_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written,
  output logic              chk_err
);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(2**ADDR_W);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
  assign chk_err = 1'b0;
`endif
  state_t          state;
  logic [ADDR_W:0] count;
  logic [1:0]      idx;
  logic [23:0]     wbuf;
  logic [ADDR_W:0] clamped;
  logic            last_word;
  // Clamping the count to DEPTH keeps the address from ever wrapping.
  assign clamped   = num_words > DEPTH_W ? DEPTH_W : num_words;
  assign last_word = (words_written + 1'b1) == count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      byte_ready    <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
      count         <= '0;
      idx           <= '0;
      wbuf          <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= '0;
      chk_err       <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          count         <= clamped;
          mem_addr      <= '0;
          words_written <= '0;
          idx           <= '0;
          busy          <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum          <= '0;
          chk_err       <= 1'b0;
          state         <= clamped == '0 ? CHECK : LOAD;
          byte_ready    <= 1'b1;
`else
          state         <= clamped == '0 ? DONE : LOAD;
          byte_ready    <= clamped != '0;
          done          <= clamped == '0;
`endif
        end
        LOAD: if (byte_valid) begin
          idx <= idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum <= csum ^ byte_data;
`endif
          // Lanes 0..2 park in wbuf; the fourth byte completes the word directly.
          if (idx == 2'd3) begin
            mem_wdata  <= {byte_data, wbuf};
            mem_we     <= 1'b1;
            byte_ready <= 1'b0;
            state      <= WRITE;
          end else begin
            wbuf[{idx, 3'b000} +: 8] <= byte_data;
          end
        end
        WRITE: begin
          mem_addr      <= mem_addr + 1'b1;
          words_written <= words_written + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          state         <= last_word ? CHECK : LOAD;
          byte_ready    <= 1'b1;
`else
          state         <= last_word ? DONE : LOAD;
          byte_ready    <= !last_word;
          done          <= last_word;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: if (byte_valid) begin
          chk_err    <= byte_data != csum;
          byte_ready <= 1'b0;
          done       <= 1'b1;
          state      <= DONE;
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_byte_word_loader.sv
// tb_byte_word_loader: directed bench with a word-level reference model for byte_word_loader.
module tb_byte_word_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  num_words = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, mem_we, busy, done, chk_err;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [5:0]  words_written;

  int checks = 0;
  int errors = 0;
  int nwrites = 0;
  int ndone = 0;
  logic [36:0] exp_q[$];
  logic [4:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [7:0]  stream[0:127];

  byte_word_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .words_written(words_written), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every write must be the next expected {addr, word}; a write with nothing expected is an error.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      checks++;
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      nwrites++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got=%0h:%08h expected=none", mem_addr, mem_wdata);
      end else if ({mem_addr, mem_wdata} !== exp_q[0] || busy !== 1'b1 || byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL write got=%0h:%08h busy=%b rdy=%b expected=%0h:%08h busy=1 rdy=0",
                 mem_addr, mem_wdata, busy, byte_ready, exp_q[0][36:32], exp_q[0][31:0]);
        void'(exp_q.pop_front());
      end else void'(exp_q.pop_front());
    end
    if (rst_n && done) ndone++;
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      errors++;
      $display("FAIL byte_timeout got=not_ready expected=ready");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic session(input int n, input bit toggle, input bit mid_start, input logic [7:0] ck);
    int nw = n > 32 ? 32 : n;
    int t = 0;
    logic [7:0] x = '0;
    for (int i = 0; i < 4 * nw; i++) x ^= stream[i];
    for (int i = 0; i < nw; i++)
      exp_q.push_back({5'(i), stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]});
    log_addr.delete(); log_data.delete();
    nwrites = 0; ndone = 0;
    start = 1'b1; num_words = 6'(n);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("chk_err_cleared", chk_err, 0);
    for (int i = 0; i < 4 * nw; i++) begin
      send_byte(stream[i]);
      if (toggle) @(negedge clk);
      if (mid_start && i == 2) begin
        start = 1'b1; num_words = 6'd5;
        @(negedge clk);
        start = 1'b0;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(ck);
`endif
    while (!done && t < 20) begin @(negedge clk); t++; end
    chk("done_seen", done, 1);
`ifdef LOADER_CHECKSUM_EN
    chk("chk_err", chk_err, ck != x);
`else
    chk("chk_err", chk_err, 0);
`endif
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_drop", busy, 0);
    chk("done_count", ndone, 1);
    chk("write_count", nwrites, nw);
    chk("words_written", words_written, nw);
    chk("exp_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words_written", words_written, 0);
    chk("rst_chk_err", chk_err, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_byte_ready", byte_ready, 0);
    chk("idle_busy", busy, 0);

    // Two words back-to-back, pinned against hand-computed words.
    {stream[0], stream[1], stream[2], stream[3]} = {8'h11, 8'h22, 8'h33, 8'h44};
    {stream[4], stream[5], stream[6], stream[7]} = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    session(2, 0, 0, 8'h00);
    chk("lit_word0", log_data.size() > 0 ? log_data[0] : 32'hX, 32'h44332211);
    chk("lit_word1", log_data.size() > 1 ? log_data[1] : 32'hX, 32'hDDCCBBAA);
    chk("lit_addr1", log_addr.size() > 1 ? log_addr[1] : 5'hX, 5'd1);

    // Same stream, gapped valid and an ignored start mid-session.
    session(2, 1, 1, 8'h00);
    chk("lit_gap_word1", log_data.size() > 1 ? log_data[1] : 32'hX, 32'hDDCCBBAA);

    // Oversized count clamps to 32 words without wrapping.
    for (int i = 0; i < 128; i++) stream[i] = 8'(i * 7 + 3);
    session(40, 0, 0, 8'h00);
    chk("lit_clamp_writes", nwrites, 32);
    chk("lit_last_addr", log_addr.size() == 32 ? log_addr[31] : 5'hX, 5'd31);
    chk("lit_clamp_ww", words_written, 6'd32);

    // Empty session.
    session(0, 0, 0, 8'h00);

    // Reset mid-session discards the partial word.
    start = 1'b1; num_words = 6'd2;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h55); send_byte(8'h66);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {byte_ready, mem_we, mem_addr, mem_wdata, busy, done, words_written, chk_err}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    {stream[0], stream[1], stream[2], stream[3]} = {8'h01, 8'h02, 8'h03, 8'h04};
    session(1, 0, 0, 8'h00);
    chk("lit_after_rst", log_data.size() > 0 ? {27'd0, log_addr[0], log_data[0]} : 64'hX, {27'd0, 5'd0, 32'h04030201});

    // Checksum byte: 01^02^04^08 = 0F.
    {stream[0], stream[1], stream[2], stream[3]} = {8'h01, 8'h02, 8'h04, 8'h08};
    session(1, 0, 0, 8'h0F);
    chk("lit_ck_ok", chk_err, 0);
    session(1, 0, 0, 8'h0E);
    repeat (3) @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
    chk("lit_ck_bad_held", chk_err, 1);
`else
    chk("lit_ck_tied", chk_err, 0);
`endif
    session(1, 0, 0, 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
